// File: rtl/pad_ctrl_pkg.sv
// Shared types for the pad ownership controller: FSM state encoding,
// wide pad/owner index types used for request range checks, and a helper.
package pad_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_TURN   = 2'd1,
        ST_COMMIT = 2'd2
    } state_e;

    // Wide enough for any supported pad/owner count (up to 65535).
    localparam int unsigned IdxW = 16;

    typedef logic [IdxW-1:0] pad_idx_t;
    typedef logic [IdxW-1:0] owner_idx_t;

    // True when idx addresses one of 'limit' entries.
    function automatic logic idx_in_range(input logic [IdxW-1:0] idx,
                                          input int unsigned     limit);
        return 32'(idx) < limit;
    endfunction

endpackage

// File: rtl/pad_in_sync.sv
// Two-flop synchronizer for one asynchronous pad input.
// Ports:
//   clk_i  - clock
//   rst_ni - asynchronous active-low reset (both flops clear to 0)
//   d_i    - asynchronous input from the pad cell
//   q_o    - synchronized output, two cycles of latency
module pad_in_sync (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= 1'b0;
            q_o    <= 1'b0;
        end else begin
            meta_q <= d_i;
            q_o    <= meta_q;
        end
    end

endmodule

// File: rtl/pad_owner_ctrl.sv
// Pad ownership controller: muxes per-owner drive data and output enables
// onto bidirectional pad cells, and re-assigns a pad to another owner with a
// tristated turnaround so two owners never drive the pad back to back.
// Ports:
//   clk_i, rst_ni            - clock, asynchronous active-low reset
//   cfg_valid_i/cfg_ready_o  - ownership-change request handshake (ready only in IDLE)
//   cfg_pad_i, cfg_owner_i   - target pad and new owner; one bit wider than the
//                              index so out-of-range requests can be expressed
//   cfg_err_o                - one-cycle pulse after an out-of-range request
//   own_out_i, own_oe_i      - per-owner drive data / output enable, owner o at [o*NumPads +: NumPads]
//   own_in_o                 - synchronized pad inputs, broadcast to all owners
//   pad_in_o, pad_oen_o      - to pad cells (OEN active-low)
//   pad_out_i                - from pad cells, asynchronous
//   owner_o                  - current owner of pad p at [p*OwnerW +: OwnerW]
//   busy_o                   - turnaround in progress
module pad_owner_ctrl
    import pad_ctrl_pkg::*;
#(
    parameter  int unsigned NumPads    = 8,
    parameter  int unsigned NumOwners  = 4,
    parameter  int unsigned TurnCycles = 2,
    localparam int unsigned PadW       = (NumPads > 1) ? $clog2(NumPads) : 1,
    localparam int unsigned OwnerW     = (NumOwners > 1) ? $clog2(NumOwners) : 1,
    localparam int unsigned CfgPadW    = PadW + 1,
    localparam int unsigned CfgOwnerW  = OwnerW + 1
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    input  logic                           cfg_valid_i,
    output logic                           cfg_ready_o,
    input  logic [CfgPadW-1:0]             cfg_pad_i,
    input  logic [CfgOwnerW-1:0]           cfg_owner_i,
    output logic                           cfg_err_o,
    input  logic [NumOwners*NumPads-1:0]   own_out_i,
    input  logic [NumOwners*NumPads-1:0]   own_oe_i,
    output logic [NumPads-1:0]             own_in_o,
    output logic [NumPads-1:0]             pad_in_o,
    output logic [NumPads-1:0]             pad_oen_o,
    input  logic [NumPads-1:0]             pad_out_i,
    output logic [NumPads*OwnerW-1:0]      owner_o,
    output logic                           busy_o
);

    localparam int unsigned CntW = (TurnCycles > 1) ? $clog2(TurnCycles) : 1;

    state_e              state_q;
    logic [CntW-1:0]     cnt_q;
    logic [PadW-1:0]     tgt_pad_q;
    logic [OwnerW-1:0]   tgt_owner_q;
    logic [OwnerW-1:0]   owner_q [NumPads];
    logic                ready_q;
    logic                busy_q;
    logic                err_q;

    logic [NumPads-1:0]  own_out_a [NumOwners];
    logic [NumPads-1:0]  own_oe_a  [NumOwners];

    logic                pad_ok_c;
    logic                owner_ok_c;
    logic [OwnerW-1:0]   cur_owner_c;
    logic                accept_c;
    logic                change_c;
    logic [NumPads-1:0]  force_c;

    // Per-owner views of the flattened drive buses.
    for (genvar o = 0; o < NumOwners; o++) begin : g_own_view
        assign own_out_a[o] = own_out_i[o*NumPads +: NumPads];
        assign own_oe_a[o]  = own_oe_i[o*NumPads +: NumPads];
    end

    // Request decode; the owner lookup is only meaningful when the pad is in range.
    always_comb begin
        pad_ok_c    = idx_in_range(pad_idx_t'(cfg_pad_i), NumPads);
        owner_ok_c  = idx_in_range(owner_idx_t'(cfg_owner_i), NumOwners);
        cur_owner_c = owner_q[cfg_pad_i[PadW-1:0]];
        accept_c    = cfg_valid_i & ready_q;
        change_c    = pad_ok_c & owner_ok_c & (cfg_owner_i[OwnerW-1:0] != cur_owner_c);
    end

    // Ownership FSM; ready/busy are registered alongside the state.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            tgt_pad_q   <= '0;
            tgt_owner_q <= '0;
            ready_q     <= 1'b1;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
            for (int p = 0; p < NumPads; p++) begin
                owner_q[p] <= '0;
            end
        end else begin
            err_q <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (accept_c) begin
                        if (!(pad_ok_c && owner_ok_c)) begin
                            err_q <= 1'b1;
                        end else if (change_c) begin
                            tgt_pad_q   <= cfg_pad_i[PadW-1:0];
                            tgt_owner_q <= cfg_owner_i[OwnerW-1:0];
                            cnt_q       <= '0;
                            state_q     <= ST_TURN;
                            ready_q     <= 1'b0;
                            busy_q      <= 1'b1;
                        end
                    end
                end
                ST_TURN: begin
                    // Owner switches on the edge that leaves TURN so the
                    // force is released in the very cycle the new owner appears.
                    if (cnt_q == CntW'(TurnCycles - 1)) begin
                        owner_q[tgt_pad_q] <= tgt_owner_q;
                        state_q            <= ST_COMMIT;
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
                ST_COMMIT: begin
                    state_q <= ST_IDLE;
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // Pad mux from the registered owner; reset overrides to a safe tristate.
    always_comb begin
        pad_in_o  = '0;
        pad_oen_o = '1;
        force_c   = '0;
        for (int p = 0; p < NumPads; p++) begin
            force_c[p] = (state_q == ST_TURN) && (tgt_pad_q == PadW'(p));
        end
        if (rst_ni) begin
            for (int p = 0; p < NumPads; p++) begin
                pad_in_o[p]  = own_out_a[owner_q[p]][p];
                pad_oen_o[p] = ~own_oe_a[owner_q[p]][p] | force_c[p];
            end
        end
    end

    for (genvar p = 0; p < NumPads; p++) begin : g_pad
        pad_in_sync u_sync (
            .clk_i  (clk_i),
            .rst_ni (rst_ni),
            .d_i    (pad_out_i[p]),
            .q_o    (own_in_o[p])
        );
        assign owner_o[p*OwnerW +: OwnerW] = owner_q[p];
    end

    assign cfg_ready_o = ready_q;
    assign busy_o      = busy_q;
    assign cfg_err_o   = err_q;

endmodule
